// File: rtl/vga_bw_framebuf.sv
// 1-bpp framebuffer for a 640x480 VGA timing core: 2x2 pixel doubling from a
// FB_W x FB_H bitmap, single write port shared between user writes and a fill engine.
module vga_bw_framebuf #(
   parameter int unsigned FB_W     = 320,
   parameter int unsigned FB_H     = 240,
   parameter int unsigned FB_WORDS = 4800
) (
   input  logic        clk_25mhz,
   input  logic        reset,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        active_in,
   input  logic [9:0]  hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [12:0] wr_addr,
   input  logic [15:0] wr_data,
   input  logic        clear_req,
   input  logic        clear_val,
   output logic        busy,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        video
);

   localparam int unsigned AW        = 13;
   localparam int unsigned DW        = 16;
   localparam int unsigned ROW_WORDS = FB_W / DW;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state;
   logic [AW-1:0]   clr_ptr;
   logic            clr_val;

   logic [DW-1:0]   mem [0:FB_WORDS-1];
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   rd_data;

   logic [8:0]      fb_x;
   logic [8:0]      fb_y;
   logic            in_fb;
   logic [AW-1:0]   pix_addr;

   logic            s1_hs, s1_vs, s1_act;
   logic [3:0]      s1_bit;
   logic [AW-1:0]   rd_addr;
   logic            s2_hs, s2_vs, s2_act;
   logic [3:0]      s2_bit;

   logic            unused_lsbs;
   assign unused_lsbs = ^{hcount_in[0], vcount_in[0]};

   // Clear request wins over a same-cycle user write; reset keeps the port open.
   assign wr_ready = (state == IDLE) && (reset || !clear_req);
   assign busy     = (state == CLEAR);

   // Fill engine: latch value, sweep pointer across every word once.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state   <= IDLE;
         clr_ptr <= '0;
         clr_val <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state   <= CLEAR;
                  clr_ptr <= '0;
                  clr_val <= clear_val;
               end
            end
            CLEAR: begin
               if (clr_ptr == AW'(FB_WORDS - 1)) begin
                  state <= IDLE;
               end else begin
                  clr_ptr <= clr_ptr + AW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Write-port arbitration; an aborting reset must not land the in-flight fill word.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      if (state == CLEAR) begin
         mem_we    = !reset;
         mem_waddr = clr_ptr;
         mem_wdata = {DW{clr_val}};
      end else if (wr_valid && wr_ready && (wr_addr < AW'(FB_WORDS))) begin
         mem_we = 1'b1;
      end
   end

   // Storage is never reset; read returns pre-write data on an address collision.
   always_ff @(posedge clk_25mhz) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      rd_data <= mem[rd_addr];
   end

   assign fb_x     = hcount_in[9:1];
   assign fb_y     = vcount_in[9:1];
   assign in_fb    = ({1'b0, fb_x} < 10'(FB_W)) && ({1'b0, fb_y} < 10'(FB_H));
   assign pix_addr = AW'(fb_y) * AW'(ROW_WORDS) + AW'(fb_x[8:4]);

   // Display pipeline: address register, RAM read, bit select.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         s1_hs     <= 1'b0;
         s1_vs     <= 1'b0;
         s1_act    <= 1'b0;
         s1_bit    <= '0;
         rd_addr   <= '0;
         s2_hs     <= 1'b0;
         s2_vs     <= 1'b0;
         s2_act    <= 1'b0;
         s2_bit    <= '0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         video     <= 1'b0;
      end else begin
         s1_hs     <= hsync_in;
         s1_vs     <= vsync_in;
         s1_act    <= active_in;
         s1_bit    <= ~fb_x[3:0];
         rd_addr   <= in_fb ? pix_addr : '0;
         s2_hs     <= s1_hs;
         s2_vs     <= s1_vs;
         s2_act    <= s1_act;
         s2_bit    <= s1_bit;
         hsync_out <= s2_hs;
         vsync_out <= s2_vs;
         video     <= s2_act & rd_data[s2_bit];
      end
   end

endmodule

// File: tb/tb_vga_bw_framebuf.sv
// Directed bench for vga_bw_framebuf: reference bitmap plus a 3-deep expectation queue
// for the display pipeline.
module tb_vga_bw_framebuf;

   localparam int WORDS = 4800;

   logic        clk_25mhz = 1'b0;
   logic        reset;
   logic        hsync_in, vsync_in, active_in;
   logic [9:0]  hcount_in, vcount_in;
   logic        wr_valid, wr_ready;
   logic [12:0] wr_addr;
   logic [15:0] wr_data;
   logic        clear_req, clear_val, busy;
   logic        hsync_out, vsync_out, video;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] model [WORDS];
   logic [2:0]  q [$];
   logic [11:0] hpat, vpat;

   vga_bw_framebuf dut (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .hsync_in  (hsync_in),
      .vsync_in  (vsync_in),
      .active_in (active_in),
      .hcount_in (hcount_in),
      .vcount_in (vcount_in),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .clear_req (clear_req),
      .clear_val (clear_val),
      .busy      (busy),
      .hsync_out (hsync_out),
      .vsync_out (vsync_out),
      .video     (video)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   initial begin
      #10000000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_25mhz);
      #1;
   endtask

   function automatic logic model_px(input int hc, input int vc);
      int x, y, w;
      x = hc / 2;
      y = vc / 2;
      w = y * 20 + x / 16;
      return model[w][15 - (x % 16)];
   endfunction

   // One display cycle; outputs are compared against the pixel driven 3 cycles earlier.
   task automatic step(input logic hs, input logic vs, input logic act, input int hc, input int vc);
      logic [2:0] e;
      hsync_in  = hs;
      vsync_in  = vs;
      active_in = act;
      hcount_in = 10'(hc);
      vcount_in = 10'(vc);
      q.push_back({act ? model_px(hc, vc) : 1'b0, hs, vs});
      tick();
      if (q.size() == 3) begin
         e = q.pop_front();
         chk("video",     16'(video),     16'(e[2]));
         chk("hsync_out", 16'(hsync_out), 16'(e[1]));
         chk("vsync_out", 16'(vsync_out), 16'(e[0]));
      end
   endtask

   task automatic drain();
      step(1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b0, 1'b0, 0, 0);
      q.delete();
   endtask

   task automatic scan_word(input int w);
      int x;
      for (int b = 0; b < 16; b++) begin
         x = (w % 20) * 16 + b;
         step(1'((b >> 0) & 1), 1'((b >> 1) & 1), 1'b1, 2 * x, 2 * (w / 20) + 1);
      end
   endtask

   task automatic do_write(input int addr, input logic [15:0] data);
      wr_valid = 1'b1;
      wr_addr  = 13'(addr);
      wr_data  = data;
      #1;
      chk("wr_ready_on_write", 16'(wr_ready), 16'd1);
      tick();
      wr_valid = 1'b0;
      if (addr < WORDS) model[addr] = data;
   endtask

   // Full fill; a restart attempt mid-fill must not extend or alter it.
   task automatic full_clear(input logic val);
      int n;
      clear_val = val;
      clear_req = 1'b1;
      wr_valid  = 1'b1;
      wr_addr   = 13'd7;
      wr_data   = 16'h5A5A;
      #1;
      chk("wr_ready_with_clear_req", 16'(wr_ready), 16'd0);
      tick();
      clear_req = 1'b0;
      wr_valid  = 1'b0;
      clear_val = ~val;
      n = 0;
      while (busy === 1'b1 && n < 6000) begin
         clear_req = (n == 10);
         if (n == 20) chk("wr_ready_in_clear", 16'(wr_ready), 16'd0);
         n++;
         tick();
      end
      clear_req = 1'b0;
      chk("busy_cycles", 16'(n), 16'd4800);
      chk("busy_after_clear", 16'(busy), 16'd0);
      chk("wr_ready_after_clear", 16'(wr_ready), 16'd1);
      for (int w = 0; w < WORDS; w++) model[w] = {16{val}};
   endtask

   initial begin
      reset = 1'b1;
      hsync_in = 1'b1; vsync_in = 1'b1; active_in = 1'b1;
      hcount_in = '0; vcount_in = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      clear_req = 1'b0; clear_val = 1'b0;
      tick();
      tick();
      chk("rst_video",    16'(video),     16'd0);
      chk("rst_hsync",    16'(hsync_out), 16'd0);
      chk("rst_vsync",    16'(vsync_out), 16'd0);
      chk("rst_busy",     16'(busy),      16'd0);
      chk("rst_wr_ready", 16'(wr_ready),  16'd1);
      reset = 1'b0;
      q.delete();

      full_clear(1'b0);

      // Top-left pixel doubled over 2x2 screen pixels.
      do_write(0, 16'h8000);
      step(1'b1, 1'b0, 1'b1, 0, 0);
      step(1'b0, 1'b1, 1'b1, 1, 0);
      step(1'b1, 1'b1, 1'b1, 0, 1);
      step(1'b0, 1'b0, 1'b1, 1, 1);
      step(1'b1, 1'b0, 1'b1, 2, 0);
      step(1'b0, 1'b1, 1'b1, 2, 1);
      step(1'b0, 1'b0, 1'b1, 31, 0);
      step(1'b0, 1'b0, 1'b1, 32, 0);
      drain();

      do_write(21, 16'hA5C3);
      scan_word(21);
      drain();

      // Bottom-right pixel.
      do_write(4799, 16'h0001);
      for (int vc = 476; vc < 480; vc++)
         for (int hc = 636; hc < 640; hc++)
            step(1'b0, 1'b0, 1'b1, hc, vc);
      drain();

      // Out-of-range write is accepted and discarded.
      do_write(5000, 16'h1234);
      scan_word(200);
      scan_word(808);
      scan_word(904);
      drain();

      full_clear(1'b1);
      for (int w = 0; w < WORDS; w++) begin
         step(1'b0, 1'b0, 1'b1,
              2 * ((w % 20) * 16 + (w * 7) % 16) + (w & 1),
              2 * (w / 20) + ((w >> 1) & 1));
      end
      drain();

      // Syncs pass with 3-cycle delay; video blanked while inactive.
      hpat = 12'b1011_0011_1000;
      vpat = 12'b1100_1010_0110;
      for (int i = 0; i < 12; i++) step(hpat[i], vpat[i], 1'b0, i * 50, i * 37);
      drain();

      // Aborted fill; the same-cycle user write must never land.
      clear_val = 1'b0;
      clear_req = 1'b1;
      wr_valid  = 1'b1;
      wr_addr   = 13'd4000;
      wr_data   = 16'h0000;
      #1;
      chk("wr_ready_clear_collide", 16'(wr_ready), 16'd0);
      tick();
      clear_req = 1'b0;
      wr_valid  = 1'b0;
      chk("busy_start", 16'(busy), 16'd1);
      repeat (100) tick();
      reset = 1'b1;
      tick();
      chk("abort_busy",     16'(busy),     16'd0);
      chk("abort_wr_ready", 16'(wr_ready), 16'd1);
      chk("abort_video",    16'(video),    16'd0);
      reset = 1'b0;
      q.delete();
      for (int w = 0; w < 100; w++) model[w] = 16'h0000;
      scan_word(0);
      scan_word(50);
      scan_word(99);
      scan_word(100);
      scan_word(101);
      scan_word(150);
      scan_word(4000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
